// File: rtl/bcd_digit_accumulator_if.sv
// Digit-in / result-out handshake bundle for bcd_digit_accumulator.
// The slave modport is the accumulator; the master modport is whoever feeds digits and takes results.
interface bcd_digit_accumulator_if #(
    parameter int NDIG = 4,
    parameter int W    = 14
);
    localparam int CW = $clog2(NDIG + 1);

    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_digit;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_value;
    logic [CW-1:0] out_ndig;
    logic          out_bad_digit;
    logic          out_overflow;

    modport master (
        output in_valid, in_digit, in_last, out_ready,
        input  in_ready, out_valid, out_value, out_ndig, out_bad_digit, out_overflow
    );

    modport slave (
        input  in_valid, in_digit, in_last, out_ready,
        output in_ready, out_valid, out_value, out_ndig, out_bad_digit, out_overflow
    );
endinterface

// File: rtl/bcd_digit_accumulator.sv
// Folds decimal digits (MSD first) into a binary value, acc = acc*10 + digit, and
// presents the finished number with digit count and sticky bad-digit / overflow flags.
module bcd_digit_accumulator #(
    parameter int NDIG = 4,
    parameter int W    = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    bcd_digit_accumulator_if.slave   bus
);
    localparam int            CW     = $clog2(NDIG + 1);
    localparam int            WX     = W + 4;
    localparam logic [CW-1:0] NDIG_C = CW'(NDIG);

    typedef enum logic {ACC, HOLD} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] count_q, count_d;
    logic          bad_q, bad_d;
    logic          ovf_q, ovf_d;
    logic          load_out;

    logic [W-1:0]  out_value_q;
    logic [CW-1:0] out_ndig_q;
    logic          out_bad_q;
    logic          out_ovf_q;

    logic          digit_bad;
    logic [3:0]    eff_digit;
    logic [WX-1:0] acc_wide;
    logic [WX-1:0] acc_sum;
    logic [W-1:0]  acc_upd;

    // Illegal digits still count as a digit position but contribute zero.
    assign digit_bad = (bus.in_digit > 4'd9);
    assign eff_digit = digit_bad ? 4'd0 : bus.in_digit;
    assign acc_wide  = WX'(acc_q);
    assign acc_sum   = (acc_wide << 3) + (acc_wide << 1) + WX'(eff_digit);
    assign acc_upd   = W'(acc_sum);

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        count_d  = count_q;
        bad_d    = bad_q;
        ovf_d    = ovf_q;
        load_out = 1'b0;

        case (state_q)
            ACC: begin
                if (bus.in_valid) begin
                    bad_d = bad_q | digit_bad;
                    if (count_q < NDIG_C) begin
                        acc_d   = acc_upd;
                        count_d = count_q + CW'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (bus.in_last) begin
                        load_out = 1'b1;
                        state_d  = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = ACC;
                    acc_d   = '0;
                    count_d = '0;
                    bad_d   = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ACC;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACC;
            acc_q   <= '0;
            count_q <= '0;
            bad_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            bad_q   <= bad_d;
            ovf_q   <= ovf_d;
        end
    end

    // Result fields load only when a number closes and otherwise keep their last values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_value_q <= '0;
            out_ndig_q  <= '0;
            out_bad_q   <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else if (load_out) begin
            out_value_q <= acc_d;
            out_ndig_q  <= count_d;
            out_bad_q   <= bad_d;
            out_ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready      = (state_q == ACC);
    assign bus.out_valid     = (state_q == HOLD);
    assign bus.out_value     = out_value_q;
    assign bus.out_ndig      = out_ndig_q;
    assign bus.out_bad_digit = out_bad_q;
    assign bus.out_overflow  = out_ovf_q;
endmodule
